// File: rtl/dcache_refill_ctrl_if.sv
// rtl/dcache_refill_ctrl_if.sv - bus bundle between the refill controller and its neighbours
// Purpose: groups the miss request, store-hit request, memory read channel,
//          data-array write port and status signals of dcache_refill_ctrl.
// Modports:
//   master - the refill controller (drives readies, mem request, data-array writes, status)
//   slave  - the surrounding system (cache FSM, memory, data arrays)
interface dcache_refill_ctrl_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int WAYS         = 4,
  parameter int INDEX_WIDTH  = 3,
  parameter int OFFSET_WIDTH = 5,
  parameter int ADDR_WIDTH   = 32
);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  // Miss (refill) request
  logic                    miss_valid;
  logic                    miss_ready;
  logic [ADDR_WIDTH-1:0]   miss_addr;
  logic [WAY_W-1:0]        miss_way;
  // Store-hit write request
  logic                    hit_wr_valid;
  logic                    hit_wr_ready;
  logic [ADDR_WIDTH-1:0]   hit_wr_addr;
  logic [WAY_W-1:0]        hit_wr_way;
  logic [DATA_WIDTH-1:0]   hit_wr_data;
  logic [STRB_W-1:0]       hit_wr_strb;
  // Memory burst read
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic [7:0]              mem_req_len;
  logic                    mem_rsp_valid;
  logic                    mem_rsp_ready;
  logic [DATA_WIDTH-1:0]   mem_rsp_data;
  logic                    mem_rsp_last;
  // Data-array write port
  logic [WAYS-1:0]         da_wen;
  logic [INDEX_WIDTH-1:0]  da_waddr;
  logic [DATA_WIDTH-1:0]   da_wdata;
  logic                    da_wr_hit;
  logic [OFFSET_WIDTH-1:0] da_offset;
  logic [STRB_W-1:0]       da_strb;
  // Status
  logic                    busy;
  logic                    refill_done;
  logic                    refill_err;

  modport master (
    input  miss_valid, miss_addr, miss_way,
    input  hit_wr_valid, hit_wr_addr, hit_wr_way, hit_wr_data, hit_wr_strb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_last,
    output miss_ready, hit_wr_ready,
    output mem_req_valid, mem_req_addr, mem_req_len, mem_rsp_ready,
    output da_wen, da_waddr, da_wdata, da_wr_hit, da_offset, da_strb,
    output busy, refill_done, refill_err
  );

  modport slave (
    output miss_valid, miss_addr, miss_way,
    output hit_wr_valid, hit_wr_addr, hit_wr_way, hit_wr_data, hit_wr_strb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_last,
    input  miss_ready, hit_wr_ready,
    input  mem_req_valid, mem_req_addr, mem_req_len, mem_rsp_ready,
    input  da_wen, da_waddr, da_wdata, da_wr_hit, da_offset, da_strb,
    input  busy, refill_done, refill_err
  );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// rtl/dcache_refill_ctrl.sv - serialises line refills and store-hit writes into the data arrays
// Purpose: accepts refill requests (burst read from memory, beats written in
//          shift-in mode) and single-word store hits (byte-masked merge mode),
//          driving a one-hot way enable into the per-way data arrays.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - dcache_refill_ctrl_if.master: miss/hit requests, memory read
//         channel, data-array write port, busy/refill_done/refill_err
module dcache_refill_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int WORDS        = 8,
  parameter int WAYS         = 4,
  parameter int INDEX_WIDTH  = 3,
  parameter int OFFSET_WIDTH = 5,
  parameter int ADDR_WIDTH   = 32
) (
  input logic             clk,
  input logic             rst,
  dcache_refill_ctrl_if.master bus
);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W  = $clog2(WORDS) + 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RECV  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WAY_W-1:0]      r_way;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_err;

  logic w_miss_hs;
  logic w_beat_hs;
  logic w_cnt_full;

  assign w_cnt_full = (r_cnt == CNT_W'(WORDS - 1));

  // Low address bits of the miss and high bits of the store address are
  // intentionally unused; fold them here so the intent is explicit.
  logic w_unused_bits;
  assign w_unused_bits = ^{bus.miss_addr[OFFSET_WIDTH-1:0], bus.hit_wr_addr[1:0],
                           bus.hit_wr_addr[ADDR_WIDTH-1:OFFSET_WIDTH+INDEX_WIDTH]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_miss_hs         = 1'b0;
    w_beat_hs         = 1'b0;
    bus.miss_ready    = 1'b0;
    bus.hit_wr_ready  = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = r_addr;
    bus.mem_req_len   = 8'(WORDS - 1);
    bus.mem_rsp_ready = 1'b0;
    bus.da_wen        = '0;
    bus.da_waddr      = '0;
    bus.da_wdata      = '0;
    bus.da_wr_hit     = 1'b0;
    bus.da_offset     = '0;
    bus.da_strb       = '0;
    bus.busy          = (r_state != IDLE);
    bus.refill_done   = 1'b0;
    bus.refill_err    = 1'b0;

    case (r_state)
      IDLE: begin
        bus.miss_ready   = 1'b1;
        // A pending miss always wins over a store hit.
        bus.hit_wr_ready = !bus.miss_valid;
        if (bus.miss_valid) begin
          w_miss_hs   = 1'b1;
          w_state_nxt = REQ;
        end else if (bus.hit_wr_valid) begin
          bus.da_wen    = WAYS'(1) << bus.hit_wr_way;
          bus.da_waddr  = bus.hit_wr_addr[OFFSET_WIDTH +: INDEX_WIDTH];
          bus.da_offset = {bus.hit_wr_addr[OFFSET_WIDTH-1:2], 2'b00};
          bus.da_wr_hit = 1'b1;
          bus.da_wdata  = bus.hit_wr_data;
          bus.da_strb   = bus.hit_wr_strb;
        end
      end
      REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) w_state_nxt = RECV;
      end
      RECV: begin
        bus.mem_rsp_ready = 1'b1;
        if (bus.mem_rsp_valid) begin
          w_beat_hs     = 1'b1;
          bus.da_wen    = WAYS'(1) << r_way;
          bus.da_waddr  = r_addr[OFFSET_WIDTH +: INDEX_WIDTH];
          bus.da_wdata  = bus.mem_rsp_data;
          if (bus.mem_rsp_last)  w_state_nxt = DONE;
          else if (w_cnt_full)   w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        bus.mem_rsp_ready = 1'b1;
        if (bus.mem_rsp_valid && bus.mem_rsp_last) w_state_nxt = DONE;
      end
      DONE: begin
        bus.refill_done = 1'b1;
        bus.refill_err  = r_err;
        w_state_nxt     = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_way  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_miss_hs) begin
        r_addr <= {bus.miss_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
        r_way  <= bus.miss_way;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end
      if (w_beat_hs) begin
        r_cnt <= r_cnt + 1'b1;
        // Error when last arrives early, or the line fills without last.
        if (bus.mem_rsp_last != w_cnt_full) r_err <= 1'b1;
      end
      if (r_state == DONE) r_err <= 1'b0;
    end
  end
endmodule

// File: doc/dcache_refill_ctrl.md
Name: dcache_refill_ctrl

Overview:
- Sequences the per-way cache data arrays. Serialises two kinds of write: 8-word line refills streamed from memory, and single-word CPU store hits.
- Refill beats are written in shift-in mode (da_wr_hit=0). Store hits are written in byte-masked merge mode (da_wr_hit=1).
- Sits between the cache main FSM (miss/hit requests), the memory read channel, and the data_array instances (one-hot way enable).

Parameters:
- DATA_WIDTH, 32, word width and memory beat width.
- WORDS, 8, words per cache line (beats per refill).
- WAYS, 4, number of ways.
- INDEX_WIDTH, 3, data-array set address width.
- OFFSET_WIDTH, 5, byte-offset-in-line width, log2(WORDS*DATA_WIDTH/8).
- ADDR_WIDTH, 32, physical address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss_valid  in  1  refill request.
- miss_ready  out  1  refill request accepted.
- miss_addr  in  ADDR_WIDTH  missing address; low OFFSET_WIDTH bits ignored.
- miss_way  in  log2(WAYS)  victim way to fill.
- hit_wr_valid  in  1  store-hit write request.
- hit_wr_ready  out  1  store-hit accepted.
- hit_wr_addr  in  ADDR_WIDTH  store address.
- hit_wr_way  in  log2(WAYS)  hitting way.
- hit_wr_data  in  DATA_WIDTH  store data, already aligned to word lane 0.
- hit_wr_strb  in  DATA_WIDTH/8  byte strobes.
- mem_req_valid  out  1  memory burst read request.
- mem_req_ready  in  1  request accepted.
- mem_req_addr  out  ADDR_WIDTH  line-aligned address.
- mem_req_len  out  8  beats minus one, constant WORDS-1.
- mem_rsp_valid  in  1  read beat valid.
- mem_rsp_ready  out  1  read beat accepted.
- mem_rsp_data  in  DATA_WIDTH  beat data.
- mem_rsp_last  in  1  final beat marker.
- da_wen  out  WAYS  one-hot data-array write enable.
- da_waddr  out  INDEX_WIDTH  set index.
- da_wdata  out  DATA_WIDTH  word to write.
- da_wr_hit  out  1  1 = merge mode, 0 = shift-in mode.
- da_offset  out  OFFSET_WIDTH  byte offset (merge mode only).
- da_strb  out  DATA_WIDTH/8  byte strobes (merge mode only).
- busy  out  1  high in any state other than IDLE.
- refill_done  out  1  one-cycle pulse at end of refill.
- refill_err  out  1  one-cycle pulse coincident with refill_done when the beat count was wrong.

Behaviour:
- States: IDLE, REQ, RECV, DRAIN, DONE.
- On rst: state=IDLE, beat counter=0, all latched fields=0, err flag=0. All outputs 0 except hit_wr_ready=1 and miss_ready=1 (IDLE values).
- IDLE:
  - miss_ready=1.
  - hit_wr_ready = !miss_valid; a miss has priority over a store hit.
  - On miss handshake: latch addr with the line offset bits zeroed, latch way, zero the beat counter, go to REQ. No data-array write that cycle.
  - On hit handshake (no miss present), same cycle, combinationally: da_wen = onehot(hit_wr_way), da_waddr = addr index field, da_offset = addr offset field with bits [1:0] forced to 0, da_wr_hit=1, da_wdata=hit_wr_data, da_strb=hit_wr_strb. State stays IDLE; back-to-back hits are allowed every cycle.
- REQ: mem_req_valid=1 with the latched address; mem_req_addr and mem_req_len hold stable until ready. On mem_req_ready go to RECV.
- RECV:
  - mem_rsp_ready=1.
  - Each beat handshake, same cycle: da_wen = onehot(latched way), da_waddr = latched index, da_wr_hit=1'b0, da_wdata=mem_rsp_data, da_strb=0, da_offset=0. Counter increments.
  - last=1 with counter==WORDS-1: go to DONE, err=0.
  - last=1 with counter<WORDS-1 (short burst): the beat is still written; set err, go to DONE.
  - last=0 with counter==WORDS-1: the beat is written; set err, go to DRAIN.
- DRAIN: mem_rsp_ready=1, da_wen=0. Beats are discarded until the last handshake, then go to DONE.
- DONE: refill_done=1, refill_err=err, for exactly one cycle; clear err; go to IDLE. miss_ready=0 and hit_wr_ready=0 in this state.
- Requests are not accepted in REQ, RECV, DRAIN or DONE (both readies 0).
- da_wen is never non-zero outside an IDLE hit handshake or a RECV beat handshake; at most one bit is set.
- Async reset mid-refill returns to IDLE immediately. No done pulse is produced. Any memory beats still in flight afterwards are the system's concern.
- Counter width is log2(WORDS)+1; it does not wrap within one refill.

Test Plan:
- Reset, then miss addr=0x0000_1234, way=2; mem_req_ready=1; 8 beats 0xA0..0xA7 with last on the 8th -> mem_req_addr=0x0000_1220, len=7; da_wen=4'b0100 on each of 8 beats with waddr=1, wr_hit=0; refill_done pulses one cycle after the last beat; refill_err=0.
- Store hit addr=0x0000_0046, way=1, strb=4'b0011, data=0xBEEF in IDLE -> same-cycle da_wen=4'b0010, waddr=2, offset=5'h04, wr_hit=1, strb=4'b0011; busy stays 0.
- miss_valid and hit_wr_valid both high in IDLE -> miss accepted, hit_wr_ready=0; the hit is accepted in the first IDLE cycle after refill_done.
- Short burst, last on beat 5 -> 5 writes, then refill_done=1 with refill_err=1.
- Long burst of 10 beats -> 8 writes, 2 beats drained with da_wen=0, then done with err=1.
- Assert rst during RECV after 3 beats -> next cycle busy=0, da_wen=0, no refill_done; a new miss then refills normally.
